// File: rtl/flag_stack_pkg.sv
// ---------------------------------------------------------------------------
// cft_flag_pkg
// Shared definitions for the flag stack: flag bit positions on IBUS, FSM
// state encoding, default geometry, and a helper that places a flag word
// onto its IBUS bit positions.
// ---------------------------------------------------------------------------
package cft_flag_pkg;

    localparam int unsigned DEPTH_DEF = 8;
    localparam int unsigned PTR_W_DEF = 3;
    localparam int unsigned FLAG_W    = 5;

    localparam int unsigned FLAG_N = 15;
    localparam int unsigned FLAG_Z = 14;
    localparam int unsigned FLAG_V = 13;
    localparam int unsigned FLAG_L = 12;
    localparam int unsigned FLAG_I = 11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } fs_state_e;

    // Flag word is {N,Z,V,L,I}; all other bus bits stay zero.
    function automatic logic [15:0] flags_to_bus(input logic [FLAG_W-1:0] f);
        logic [15:0] b;
        b         = '0;
        b[FLAG_N] = f[4];
        b[FLAG_Z] = f[3];
        b[FLAG_V] = f[2];
        b[FLAG_L] = f[1];
        b[FLAG_I] = f[0];
        return b;
    endfunction

endpackage

// File: rtl/flag_stack_ram.sv
// ---------------------------------------------------------------------------
// flag_stack_ram
// DEPTH x FW register file holding saved flag words. Synchronous write,
// asynchronous read. Contents are not reset.
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address (stack pointer)
//   wdata_i  : flag word to store
//   raddr_i  : read address (stack pointer - 1)
//   rdata_o  : flag word at raddr_i
// ---------------------------------------------------------------------------
module flag_stack_ram
    import cft_flag_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned PTR_W = PTR_W_DEF,
    parameter int unsigned FW    = FLAG_W
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [FW-1:0]    wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [FW-1:0]    rdata_o
);

    logic [FW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/flag_stack.sv
// ---------------------------------------------------------------------------
// flag_stack
// Saves the live flag word {N,Z,V,L,I} on push; on pop plays it back onto
// IBUS[15:11] for one cycle with nflagwe/nibus_oe low so the flag registers
// reload from the bus on the following clk4 rise.
//   clk4             : system clock, rising edge
//   reset            : synchronous active-high reset
//   fn,fz,fv,fl,fi   : live flags, sampled on push
//   npush, npop      : active-low push / pop requests
//   ibus_out         : bus data, flags in [15:11], zero elsewhere
//   nibus_oe         : active-low bus output enable
//   nflagwe          : active-low flag-load strobe
//   depth            : occupancy 0..DEPTH
//   empty, full      : occupancy status
//   err              : sticky overflow / underflow / collision flag
// ---------------------------------------------------------------------------
module flag_stack
    import cft_flag_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned PTR_W = PTR_W_DEF,
    parameter int unsigned FW    = FLAG_W
) (
    input  logic             clk4,
    input  logic             reset,
    input  logic             fn,
    input  logic             fz,
    input  logic             fv,
    input  logic             fl,
    input  logic             fi,
    input  logic             npush,
    input  logic             npop,
    output logic [15:0]      ibus_out,
    output logic             nibus_oe,
    output logic             nflagwe,
    output logic [PTR_W:0]   depth,
    output logic             empty,
    output logic             full,
    output logic             err
);

    localparam logic [PTR_W:0] SP_ONE  = 1;
    localparam logic [PTR_W:0] SP_FULL = (PTR_W+1)'(DEPTH);

    fs_state_e      state_q, state_d;
    logic [PTR_W:0] sp_q, sp_d;
    logic           err_q, err_d;
    logic           full_q, full_d;
    logic           empty_q, empty_d;
    logic [15:0]    ibus_q, ibus_d;
    logic           noe_q, noe_d;
    logic           nwe_q, nwe_d;

    logic           push_req, pop_req;
    logic           is_full, is_empty;
    logic           ram_we;
    logic [FW-1:0]  ram_rdata;
    logic [PTR_W-1:0] ram_raddr;
    logic [PTR_W-1:0] ram_waddr;

    assign push_req  = ~npush;
    assign pop_req   = ~npop;
    assign is_full   = (sp_q == SP_FULL);
    assign is_empty  = (sp_q == '0);
    assign ram_waddr = sp_q[PTR_W-1:0];
    assign ram_raddr = PTR_W'(sp_q - SP_ONE);

    flag_stack_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .FW    (FW)
    ) u_ram (
        .clk_i   (clk4),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i ({fn, fz, fv, fl, fi}),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        err_d   = err_q;
        ibus_d  = '0;
        noe_d   = 1'b1;
        nwe_d   = 1'b1;
        ram_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (push_req && pop_req) begin
                    // Collision while idle: neither operation happens.
                    err_d = 1'b1;
                end else if (push_req) begin
                    if (is_full) begin
                        err_d = 1'b1;
                    end else begin
                        ram_we = 1'b1;
                        sp_d   = sp_q + SP_ONE;
                    end
                end else if (pop_req) begin
                    if (is_empty) begin
                        err_d = 1'b1;
                    end else begin
                        sp_d    = sp_q - SP_ONE;
                        ibus_d  = flags_to_bus(ram_rdata);
                        noe_d   = 1'b0;
                        nwe_d   = 1'b0;
                        state_d = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                // Single drive cycle; pops are ignored here, pushes still land.
                state_d = ST_IDLE;
                if (push_req) begin
                    if (is_full) begin
                        err_d = 1'b1;
                    end else begin
                        ram_we = 1'b1;
                        sp_d   = sp_q + SP_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        full_d  = (sp_d == SP_FULL);
        empty_d = (sp_d == '0);
    end

    always_ff @(posedge clk4) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sp_q    <= '0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ibus_q  <= '0;
            noe_q   <= 1'b1;
            nwe_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ibus_q  <= ibus_d;
            noe_q   <= noe_d;
            nwe_q   <= nwe_d;
        end
    end

    assign ibus_out = ibus_q;
    assign nibus_oe = noe_q;
    assign nflagwe  = nwe_q;
    assign depth    = sp_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign err      = err_q;

endmodule

// File: tb/tb_flag_stack.sv
// ---------------------------------------------------------------------------
// tb_flag_stack
// Scoreboarded bench for flag_stack: a queue-based stack model predicts
// occupancy/error state and the words expected on the bus; a monitor checks
// every strobe cycle against the expected-word queue.
// ---------------------------------------------------------------------------
module tb_flag_stack;

    logic        clk4;
    logic        reset;
    logic        fn, fz, fv, fl, fi;
    logic        npush, npop;
    logic [15:0] ibus_out;
    logic        nibus_oe;
    logic        nflagwe;
    logic [3:0]  depth;
    logic        empty, full, err;

    flag_stack #(
        .DEPTH (8),
        .PTR_W (3),
        .FW    (5)
    ) dut (
        .clk4     (clk4),
        .reset    (reset),
        .fn       (fn),
        .fz       (fz),
        .fv       (fv),
        .fl       (fl),
        .fi       (fi),
        .npush    (npush),
        .npop     (npop),
        .ibus_out (ibus_out),
        .nibus_oe (nibus_oe),
        .nflagwe  (nflagwe),
        .depth    (depth),
        .empty    (empty),
        .full     (full),
        .err      (err)
    );

    initial clk4 = 1'b0;
    always #5 clk4 = ~clk4;

    // Reference model: plain LIFO of flag words plus "bus busy this cycle".
    logic [4:0]  m_stack [$];
    logic [15:0] exp_q   [$];
    bit          m_busy;
    bit          m_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Consumer flag register V: reloads from the bus on strobe, else from ALU.
    logic reg_v;
    logic alu_we;
    logic alu_v;

    always @(posedge clk4) begin
        if (nflagwe == 1'b0)  reg_v <= ibus_out[13];
        else if (alu_we)      reg_v <= alu_v;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        check("depth",    32'(depth),    32'(m_stack.size()));
        check("empty",    32'(empty),    32'(m_stack.size() == 0));
        check("full",     32'(full),     32'(m_stack.size() == 8));
        check("err",      32'(err),      32'(m_err));
        check("nflagwe",  32'(nflagwe),  32'(!m_busy));
        check("nibus_oe", 32'(nibus_oe), 32'(!m_busy));
        if (!m_busy) check("ibus_idle", 32'(ibus_out), 32'h0);
    endtask

    function automatic void model_push(input logic [4:0] f);
        if (m_stack.size() == 8) m_err = 1'b1;
        else                     m_stack.push_back(f);
    endfunction

    // One clock: drive requests, advance the model by the stack rules, check.
    task automatic step(input bit pu, input bit po, input logic [4:0] f);
        logic [4:0] w;
        npush = !pu;
        npop  = !po;
        {fn, fz, fv, fl, fi} = f;
        @(posedge clk4);
        if (m_busy) begin
            m_busy = 1'b0;
            if (pu) model_push(f);
        end else if (pu && po) begin
            m_err = 1'b1;
        end else if (pu) begin
            model_push(f);
        end else if (po) begin
            if (m_stack.size() == 0) begin
                m_err = 1'b1;
            end else begin
                w = m_stack.pop_back();
                exp_q.push_back({w, 11'b0});
                m_busy = 1'b1;
            end
        end
        #1;
        check_state();
    endtask

    task automatic model_reset();
        m_stack.delete();
        m_busy = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic do_reset(input int cycles, input bit hold_push);
        reset = 1'b1;
        npush = !hold_push;
        npop  = 1'b1;
        repeat (cycles) @(posedge clk4);
        model_reset();
        #1;
        reset = 1'b0;
        npush = 1'b1;
        check_state();
    endtask

    // Monitor: every strobe cycle must match the next expected word.
    always @(negedge clk4) begin
        if (nflagwe == 1'b0) begin
            if (exp_q.size() == 0) begin
                check("strobe_unexpected", 32'(nflagwe), 32'h1);
            end else begin
                check("pop_data", 32'(ibus_out), 32'(exp_q.pop_front()));
                check("pop_oe",   32'(nibus_oe), 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        reset  = 1'b1;
        npush  = 1'b1;
        npop   = 1'b1;
        {fn, fz, fv, fl, fi} = '0;
        alu_we = 1'b0;
        alu_v  = 1'b0;
        reg_v  = 1'b0;
        model_reset();

        // Reset held with a push request asserted.
        do_reset(2, 1'b1);
        check("rst_depth", 32'(depth), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);

        // Single V-only word round trip.
        step(1, 0, 5'b00100);
        check("t2_depth1", 32'(depth), 32'h1);
        step(0, 1, 5'b0);
        check("t2_bus", 32'(ibus_out), 32'h2000);
        step(0, 0, 5'b0);

        // Fill, overflow, drain in LIFO order.
        for (int i = 1; i <= 8; i++) step(1, 0, 5'(i));
        step(1, 0, 5'h1f);
        check("t3_full", 32'(full), 32'h1);
        check("t3_err",  32'(err),  32'h1);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 5'b0);
            check("t3_lifo", 32'(ibus_out[15:11]), 32'(8 - i));
            step(0, 0, 5'b0);
        end
        check("t3_empty", 32'(empty), 32'h1);

        // Underflow, then collision in IDLE at depth 3.
        do_reset(1, 1'b0);
        step(0, 1, 5'b0);
        check("t4_err_underflow", 32'(err), 32'h1);
        do_reset(1, 1'b0);
        for (int i = 0; i < 3; i++) step(1, 0, 5'h0a + 5'(i));
        step(1, 1, 5'h11);
        check("t4_depth3", 32'(depth), 32'h3);

        // Collision during DRIVE: push lands, pop ignored.
        step(0, 1, 5'b0);
        step(1, 1, 5'h15);
        step(0, 0, 5'b0);

        // Reset during the drive cycle aborts it.
        do_reset(1, 1'b0);
        step(1, 0, 5'h03);
        step(1, 0, 5'h04);
        step(0, 1, 5'b0);
        reset = 1'b1;
        npop  = 1'b1;
        @(posedge clk4);
        model_reset();
        #1;
        reset = 1'b0;
        check("t5_nflagwe", 32'(nflagwe),  32'h1);
        check("t5_noe",     32'(nibus_oe), 32'h1);
        check("t5_depth",   32'(depth),    32'h0);

        // Loopback through the consumer V register.
        step(1, 0, 5'b00100);
        alu_we = 1'b1;
        alu_v  = 1'b0;
        step(0, 0, 5'b0);
        alu_we = 1'b0;
        check("t6_v_cleared", 32'(reg_v), 32'h0);
        step(0, 1, 5'b0);
        step(0, 0, 5'b0);
        check("t6_v_restored", 32'(reg_v), 32'h1);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset(1, 1'b0);
            end else begin
                step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 40,
                     5'($urandom_range(0, 31)));
            end
        end
        step(0, 0, 5'b0);
        step(0, 0, 5'b0);
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
